// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM encoding and default vector/opcode constants for the interrupt sequencer.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, RAISE, ISR, DRAIN} irq_state_e;
    localparam logic [5:0]  OP_RETI_DEF    = 6'h1E;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0F00;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0004;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        any_o = |eligible_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (eligible_i[i]) idx_o = IW'(i);
    end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: captures interrupt edges, masks and prioritises them, and
// sequences one interrupt at a time into the jump-control block.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int               N_SRC      = 4,
    parameter int               ADDR_W     = 16,
    parameter int               OP_W       = 6,
    parameter logic [ADDR_W-1:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [OP_W-1:0]   OP_RETI    = OP_RETI_DEF,
    parameter int               TAKE_TO    = 8,
    localparam int              IW         = $clog2(N_SRC),
    localparam int              CW         = $clog2(TAKE_TO + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    input  logic [OP_W-1:0]   op,
    input  logic              pc_mux_sel,
    output logic              interrupt,
    output logic [ADDR_W-1:0] vector_addr,
    output logic [N_SRC-1:0]  irq_ack,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  mask,
    output logic              in_isr,
    output logic [IW-1:0]     active_id
);
    irq_state_e        state_q;
    logic [N_SRC-1:0]  irq_prev_q, rise_q, pending_q, pending_d, mask_q, irq_ack_q, clr;
    logic [CW-1:0]     cnt_q;
    logic              interrupt_q, in_isr_q, any;
    logic [IW-1:0]     active_id_q, win;
    logic [ADDR_W-1:0] vector_q, vec_d;

    irq_prio_enc #(.N(N_SRC), .IW(IW)) u_enc (
        .eligible_i(pending_q & mask_q),
        .any_o     (any),
        .idx_o     (win)
    );

    // A rise landing on the bit being cleared wins, so the edge is never lost.
    always_comb begin
        clr       = (state_q == RAISE && pc_mux_sel) ? N_SRC'(1) << active_id_q : '0;
        pending_d = (pending_q & ~clr) | rise_q;
        vec_d     = ADDR_W'(VEC_BASE + ADDR_W'(win) * VEC_STRIDE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            irq_prev_q  <= '0;
            rise_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            irq_ack_q   <= '0;
            cnt_q       <= '0;
            interrupt_q <= 1'b0;
            in_isr_q    <= 1'b0;
            active_id_q <= '0;
            vector_q    <= '0;
        end else begin
            irq_prev_q <= irq_in;
            rise_q     <= irq_in & ~irq_prev_q;
            pending_q  <= pending_d;
            irq_ack_q  <= clr;
            if (mask_we) mask_q <= mask_wdata;
            case (state_q)
                IDLE: if (any) begin
                    active_id_q <= win;
                    vector_q    <= vec_d;
                    cnt_q       <= '0;
                    interrupt_q <= 1'b1;
                    state_q     <= RAISE;
                end
                RAISE: if (pc_mux_sel) begin
                    interrupt_q <= 1'b0;
                    in_isr_q    <= 1'b1;
                    state_q     <= ISR;
                end else if (cnt_q == CW'(TAKE_TO - 1)) begin
                    interrupt_q <= 1'b0;
                    state_q     <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                ISR: if (op == OP_RETI) begin
                    in_isr_q <= 1'b0;
                    state_q  <= DRAIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign interrupt   = interrupt_q;
    assign vector_addr = vector_q;
    assign irq_ack     = irq_ack_q;
    assign pending     = pending_q;
    assign mask        = mask_q;
    assign in_isr      = in_isr_q;
    assign active_id   = active_id_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scenario checks of the interrupt sequencer.
module tb_irq_sequencer;
    logic        clk = 0, reset = 0, mask_we = 0, pc_mux_sel = 0;
    logic [3:0]  irq_in = 0, mask_wdata = 0;
    logic [5:0]  op = 0;
    logic        interrupt, in_isr;
    logic [15:0] vector_addr;
    logic [3:0]  irq_ack, pending, mask;
    logic [1:0]  active_id;
    int checks = 0, failures = 0;

    irq_sequencer dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .op(op), .pc_mux_sel(pc_mux_sel), .interrupt(interrupt), .vector_addr(vector_addr),
        .irq_ack(irq_ack), .pending(pending), .mask(mask), .in_isr(in_isr), .active_id(active_id)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic service();
        pc_mux_sel = 1; tick();
        pc_mux_sel = 0; op = 6'h1E; tick();
        op = 0; tick();
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1; mask_wdata = m; tick();
        mask_we = 0;
    endtask

    task automatic test_reset();
        reset = 0; irq_in = 4'hF; mask_we = 1; mask_wdata = 4'hF; tick();
        checks++; if (interrupt !== 0 || in_isr !== 0 || irq_ack !== 0) begin failures++; $display("FAIL rst_ctl int=%0b isr=%0b ack=%b exp 0", interrupt, in_isr, irq_ack); end
        checks++; if (vector_addr !== 0 || active_id !== 0) begin failures++; $display("FAIL rst_vec vec=%h id=%0d exp 0", vector_addr, active_id); end
        checks++; if (pending !== 0 || mask !== 0) begin failures++; $display("FAIL rst_regs pend=%b mask=%b exp 0", pending, mask); end
        irq_in = 0; mask_we = 0; tick();
        reset = 1; tick(2);
        checks++; if (pending !== 0 || interrupt !== 0) begin failures++; $display("FAIL rst_post pend=%b int=%0b exp 0", pending, interrupt); end
    endtask

    task automatic test_single();
        set_mask(4'hF);
        irq_in = 4'b0100; tick(2);
        checks++; if (interrupt !== 0 || pending !== 4'b0100) begin failures++; $display("FAIL t2_lat int=%0b pend=%b exp 0/0100", interrupt, pending); end
        tick();
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F08 || active_id !== 2) begin failures++; $display("FAIL t2_raise int=%0b vec=%h id=%0d exp 1/0f08/2", interrupt, vector_addr, active_id); end
        pc_mux_sel = 1; tick();
        checks++; if (irq_ack !== 4'b0100 || in_isr !== 1 || interrupt !== 0 || pending !== 0) begin failures++; $display("FAIL t2_take ack=%b isr=%0b int=%0b pend=%b exp 0100/1/0/0000", irq_ack, in_isr, interrupt, pending); end
        pc_mux_sel = 0; tick();
        checks++; if (irq_ack !== 0 || in_isr !== 1) begin failures++; $display("FAIL t2_ackpulse ack=%b isr=%0b exp 0000/1", irq_ack, in_isr); end
        op = 6'h1E; tick();
        op = 0; tick();
        checks++; if (in_isr !== 0 || interrupt !== 0 || vector_addr !== 16'h0F08) begin failures++; $display("FAIL t2_reti isr=%0b int=%0b vec=%h exp 0/0/0f08", in_isr, interrupt, vector_addr); end
        irq_in = 0; tick();
    endtask

    task automatic test_back_to_back();
        irq_in = 4'b1010; tick(3);
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F04 || active_id !== 1) begin failures++; $display("FAIL t3_first int=%0b vec=%h id=%0d exp 1/0f04/1", interrupt, vector_addr, active_id); end
        pc_mux_sel = 1; tick();
        pc_mux_sel = 0;
        checks++; if (irq_ack !== 4'b0010 || pending !== 4'b1000) begin failures++; $display("FAIL t3_take ack=%b pend=%b exp 0010/1000", irq_ack, pending); end
        tick(3);
        checks++; if (interrupt !== 0 || in_isr !== 1) begin failures++; $display("FAIL t3_nonest int=%0b isr=%0b exp 0/1", interrupt, in_isr); end
        op = 6'h1E; tick();
        op = 0; tick();
        checks++; if (interrupt !== 0) begin failures++; $display("FAIL t3_drain int=%0b exp 0", interrupt); end
        tick();
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F0C || active_id !== 3) begin failures++; $display("FAIL t3_second int=%0b vec=%h id=%0d exp 1/0f0c/3", interrupt, vector_addr, active_id); end
        service();
        irq_in = 0; tick();
    endtask

    task automatic test_mask();
        set_mask(4'b1110);
        irq_in = 4'b0001; tick(5);
        checks++; if (pending !== 4'b0001 || interrupt !== 0 || mask !== 4'b1110) begin failures++; $display("FAIL t4_masked pend=%b int=%0b mask=%b exp 0001/0/1110", pending, interrupt, mask); end
        set_mask(4'hF);
        checks++; if (interrupt !== 0 || mask !== 4'hF) begin failures++; $display("FAIL t4_oldmask int=%0b mask=%b exp 0/1111", interrupt, mask); end
        tick();
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F00) begin failures++; $display("FAIL t4_unmask int=%0b vec=%h exp 1/0f00", interrupt, vector_addr); end
        service();
        irq_in = 0; tick();
    endtask

    task automatic test_timeout();
        int high = 0;
        irq_in = 4'b0010; tick(3);
        for (int i = 0; i < 8; i++) begin
            if (interrupt === 1) high++;
            if (i < 7) tick();
        end
        checks++; if (high !== 8) begin failures++; $display("FAIL t5_high cycles=%0d exp 8", high); end
        tick();
        checks++; if (interrupt !== 0 || pending !== 4'b0010) begin failures++; $display("FAIL t5_drop int=%0b pend=%b exp 0/0010", interrupt, pending); end
        tick();
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F04) begin failures++; $display("FAIL t5_reraise int=%0b vec=%h exp 1/0f04", interrupt, vector_addr); end
        service();
        irq_in = 0; tick();
    endtask

    task automatic test_reset_mid_isr();
        irq_in = 4'b0001; tick(3);
        pc_mux_sel = 1; tick();
        pc_mux_sel = 0; irq_in = 4'b1001; tick(3);
        checks++; if (in_isr !== 1 || pending !== 4'b1000) begin failures++; $display("FAIL t6_inisr isr=%0b pend=%b exp 1/1000", in_isr, pending); end
        reset = 0; tick();
        reset = 1; irq_in = 0;
        checks++; if (in_isr !== 0 || pending !== 0 || interrupt !== 0 || mask !== 0) begin failures++; $display("FAIL t6_rst isr=%0b pend=%b int=%0b mask=%b exp 0", in_isr, pending, interrupt, mask); end
        op = 6'h1E; tick(2);
        op = 0;
        checks++; if (in_isr !== 0 || interrupt !== 0) begin failures++; $display("FAIL t6_reti isr=%0b int=%0b exp 0/0", in_isr, interrupt); end
        set_mask(4'hF);
        irq_in = 4'b0100; tick(3);
        checks++; if (interrupt !== 1 || vector_addr !== 16'h0F08) begin failures++; $display("FAIL t6_idle int=%0b vec=%h exp 1/0f08", interrupt, vector_addr); end
        service();
        irq_in = 0; tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_timeout();
        test_reset_mid_isr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
